// File: rtl/exmem_trap_reg.sv
// EX->MEM pipeline register with precise trapping signed-overflow handling.
// A trapping add/addi/sub is squashed and EPC/Cause are recorded. MEM then
// receives only bubbles until the front end acknowledges the redirect to excvec.
module exmem_trap_reg #(
  parameter logic [4:0]  EXC_CODE_OV = 5'd12,
  parameter logic [31:0] EXC_VECTOR  = 32'h80000180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallM,
  input  logic        flushM,
  input  logic        validE,
  input  logic [31:0] aluoutE,
  input  logic        overflowE,
  input  logic        ovftrapE,
  input  logic [31:0] writedataE,
  input  logic [4:0]  writeregE,
  input  logic        regwriteE,
  input  logic        memwriteE,
  input  logic        memtoregE,
  input  logic [31:0] pcE,
  input  logic        excack,
  output logic [31:0] aluoutM,
  output logic [31:0] writedataM,
  output logic [4:0]  writeregM,
  output logic        regwriteM,
  output logic        memwriteM,
  output logic        memtoregM,
  output logic        validM,
  output logic        excM,
  output logic        excpend,
  output logic [31:0] excvec,
  output logic [31:0] epc,
  output logic [31:0] cause
);

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  // All MEM-stage fields in one record, so a bubble is simply '0.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memwrite;
    logic        memtoreg;
    logic [4:0]  writereg;
    logic [31:0] aluout;
    logic [31:0] writedata;
  } mem_t;

  localparam logic [31:0] CAUSE_OV = {25'b0, EXC_CODE_OV, 2'b0};

  state_t state;
  mem_t   m_q;
  mem_t   m_load;
  logic   trap_take;

  // Next MEM contents for a normal load; control bits are qualified by validE.
  always_comb begin
    // NOTE: whole-struct default first, so no field can be left unassigned and infer a latch.
    m_load           = '0;
    m_load.valid     = validE;
    m_load.regwrite  = regwriteE & validE;
    m_load.memwrite  = memwriteE & validE;
    m_load.memtoreg  = memtoregE & validE;
    m_load.writereg  = writeregE;
    m_load.aluout    = aluoutE;
    m_load.writedata = writedataE;
  end

  assign trap_take = validE & overflowE & ovftrapE;

  // Pipeline register and RUN/TRAP control. Priority: flush > TRAP squash > stall > trap > load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      m_q   <= '0;
      excM  <= 1'b0;
      epc   <= '0;
      cause <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
      excM <= 1'b0;
      if (state == TRAP && excack) begin
        state <= RUN;
      end
      if (flushM || state == TRAP) begin
        m_q <= '0;
      end else if (stallM) begin
        // Hold everything; EX holds and is re-evaluated once the stall lifts.
      end else if (trap_take) begin
        m_q   <= '0;
        epc   <= pcE;
        cause <= CAUSE_OV;
        excM  <= 1'b1;
        state <= TRAP;
      end else begin
        m_q <= m_load;
      end
    end
  end

  assign aluoutM    = m_q.aluout;
  assign writedataM = m_q.writedata;
  assign writeregM  = m_q.writereg;
  assign regwriteM  = m_q.regwrite;
  assign memwriteM  = m_q.memwrite;
  assign memtoregM  = m_q.memtoreg;
  assign validM     = m_q.valid;
  assign excpend    = (state == TRAP);
  assign excvec     = EXC_VECTOR;

endmodule

// File: tb/tb_exmem_trap_reg.sv
// Scoreboard bench for exmem_trap_reg: the driver pushes one hand-computed
// expectation per clock edge, and a monitor pops and compares after each edge.
module tb_exmem_trap_reg;

  typedef struct packed {
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [4:0]  writereg;
    logic        regwrite;
    logic        memwrite;
    logic        memtoreg;
    logic        valid;
    logic        exc;
    logic        excpend;
    logic [31:0] epc;
    logic [31:0] cause;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stallM = 1'b0, flushM = 1'b0, validE = 1'b0;
  logic [31:0] aluoutE = '0, writedataE = '0, pcE = '0;
  logic        overflowE = 1'b0, ovftrapE = 1'b0;
  logic [4:0]  writeregE = '0;
  logic        regwriteE = 1'b0, memwriteE = 1'b0, memtoregE = 1'b0;
  logic        excack = 1'b0;
  logic [31:0] aluoutM, writedataM, epc, cause, excvec;
  logic [4:0]  writeregM;
  logic        regwriteM, memwriteM, memtoregM, validM, excM, excpend;

  obs_t  act;
  obs_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  exmem_trap_reg dut (
    .clk(clk), .reset(reset), .stallM(stallM), .flushM(flushM), .validE(validE),
    .aluoutE(aluoutE), .overflowE(overflowE), .ovftrapE(ovftrapE),
    .writedataE(writedataE), .writeregE(writeregE), .regwriteE(regwriteE),
    .memwriteE(memwriteE), .memtoregE(memtoregE), .pcE(pcE), .excack(excack),
    .aluoutM(aluoutM), .writedataM(writedataM), .writeregM(writeregM),
    .regwriteM(regwriteM), .memwriteM(memwriteM), .memtoregM(memtoregM),
    .validM(validM), .excM(excM), .excpend(excpend), .excvec(excvec),
    .epc(epc), .cause(cause)
  );

  always #5 clk = ~clk;

  assign act = {aluoutM, writedataM, writeregM, regwriteM, memwriteM, memtoregM,
                validM, excM, excpend, epc, cause};

  task automatic check(input string name, input logic [138:0] got, input logic [138:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every edge with a pending expectation is compared 1 time unit later.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      obs_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, act, e);
    end
  end

  function automatic obs_t ld(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                              input logic rw, input logic mw, input logic mr, input logic v,
                              input logic [31:0] e_pc, input logic [31:0] e_cause);
    obs_t o;
    o = '0;
    o.aluout = alu; o.writedata = wd; o.writereg = wr;
    o.regwrite = rw; o.memwrite = mw; o.memtoreg = mr; o.valid = v;
    o.epc = e_pc; o.cause = e_cause;
    return o;
  endfunction

  function automatic obs_t bub(input logic exc, input logic pend,
                               input logic [31:0] e_pc, input logic [31:0] e_cause);
    obs_t o;
    o = '0;
    o.exc = exc; o.excpend = pend; o.epc = e_pc; o.cause = e_cause;
    return o;
  endfunction

  // Apply one edge worth of EX inputs and queue the expected MEM view after it.
  task automatic issue(input string name, input logic st, input logic fl, input logic v,
                       input logic [31:0] alu, input logic ov, input logic tr,
                       input logic [31:0] wd, input logic [4:0] wr, input logic rw,
                       input logic mw, input logic mr, input logic [31:0] pc,
                       input logic ack, input obs_t e);
    stallM = st; flushM = fl; validE = v; aluoutE = alu; overflowE = ov; ovftrapE = tr;
    writedataE = wd; writeregE = wr; regwriteE = rw; memwriteE = mw; memtoregE = mr;
    pcE = pc; excack = ack;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk);
    #2;
  endtask

  localparam logic [31:0] C_OV = 32'h0000_0030;

  initial begin
    #3;
    check("reset_outputs_zero", act, '0);
    check("excvec_const", {107'b0, excvec}, {107'b0, 32'h8000_0180});
    @(negedge clk);
    reset = 1'b1;
    #2;

    // Normal load, then an addu whose overflow must not trap (excack in RUN is ignored).
    issue("load", 0,0,1, 32'h1234_5678, 0,0, 32'hCAFE_0001, 5'd5, 1,0,0, 32'h0040_0000, 0,
          ld(32'h1234_5678, 32'hCAFE_0001, 5'd5, 1,0,0,1, 32'h0, 32'h0));
    issue("addu_no_trap", 0,0,1, 32'h8000_0000, 1,0, 32'h0, 5'd8, 1,0,0, 32'h0040_0004, 1,
          ld(32'h8000_0000, 32'h0, 5'd8, 1,0,0,1, 32'h0, 32'h0));
    issue("invalid_masks_ctrl", 0,0,0, 32'h0000_0055, 0,0, 32'h1, 5'd3, 1,1,1, 32'h0040_0008, 0,
          ld(32'h0000_0055, 32'h1, 5'd3, 0,0,0,0, 32'h0, 32'h0));

    // Stall holds M; a trapping overflow under stall is not evaluated.
    issue("load_before_stall", 0,0,1, 32'h1234_5678, 0,0, 32'h0, 5'd5, 1,0,0, 32'h0040_000C, 0,
          ld(32'h1234_5678, 32'h0, 5'd5, 1,0,0,1, 32'h0, 32'h0));
    issue("stall_1", 1,0,1, 32'hDEAD_BEEF, 0,0, 32'h7, 5'd9, 1,1,1, 32'h0040_0010, 0,
          ld(32'h1234_5678, 32'h0, 5'd5, 1,0,0,1, 32'h0, 32'h0));
    issue("stall_2_ovf", 1,0,1, 32'h8000_0000, 1,1, 32'h7, 5'd9, 1,0,0, 32'h0040_0010, 0,
          ld(32'h1234_5678, 32'h0, 5'd5, 1,0,0,1, 32'h0, 32'h0));
    issue("stall_3", 1,0,1, 32'hDEAD_BEEF, 0,0, 32'h7, 5'd9, 1,0,0, 32'h0040_0010, 0,
          ld(32'h1234_5678, 32'h0, 5'd5, 1,0,0,1, 32'h0, 32'h0));
    issue("flush_over_stall", 1,1,1, 32'hDEAD_BEEF, 0,0, 32'h7, 5'd9, 1,0,0, 32'h0040_0010, 0,
          bub(0,0, 32'h0, 32'h0));
    issue("flush_with_ovf", 0,1,1, 32'h8000_0000, 1,1, 32'h0, 5'd2, 1,0,0, 32'h0040_0100, 0,
          bub(0,0, 32'h0, 32'h0));
    issue("store_load", 0,0,1, 32'h1001_0000, 0,0, 32'hA5A5_A5A5, 5'd0, 0,1,0, 32'h0040_0104, 0,
          ld(32'h1001_0000, 32'hA5A5_A5A5, 5'd0, 0,1,0,1, 32'h0, 32'h0));

    // Trap capture, three squashed instructions, then acknowledge and resume.
    issue("trap_capture", 0,0,1, 32'h8000_0000, 1,1, 32'h0, 5'd4, 1,0,0, 32'h0040_0020, 0,
          bub(1,1, 32'h0040_0020, C_OV));
    issue("trap_hold_1", 0,0,1, 32'h0000_1111, 0,0, 32'h0, 5'd6, 1,0,1, 32'h0040_0024, 0,
          bub(0,1, 32'h0040_0020, C_OV));
    issue("trap_hold_2_ovf", 0,0,1, 32'h8000_0000, 1,1, 32'h0, 5'd6, 1,0,0, 32'h0040_0099, 0,
          bub(0,1, 32'h0040_0020, C_OV));
    issue("trap_hold_3_stall", 1,0,1, 32'h0000_3333, 0,0, 32'h0, 5'd6, 1,0,0, 32'h0040_002C, 0,
          bub(0,1, 32'h0040_0020, C_OV));
    issue("trap_excack", 0,0,1, 32'h0000_4444, 0,0, 32'h0, 5'd6, 1,0,0, 32'h0040_0030, 1,
          bub(0,0, 32'h0040_0020, C_OV));
    issue("resume_load", 0,0,1, 32'h1111_2222, 0,0, 32'h3, 5'd7, 1,0,1, 32'h8000_0180, 0,
          ld(32'h1111_2222, 32'h3, 5'd7, 1,0,1,1, 32'h0040_0020, C_OV));

    // Second trap, then asynchronous reset in the middle of TRAP.
    issue("trap2_capture", 0,0,1, 32'h8000_0000, 1,1, 32'h0, 5'd4, 1,0,0, 32'h0040_0200, 0,
          bub(1,1, 32'h0040_0200, C_OV));
    issue("trap2_hold", 0,0,1, 32'h0000_5555, 0,0, 32'h0, 5'd4, 1,0,0, 32'h0040_0204, 0,
          bub(0,1, 32'h0040_0200, C_OV));
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_mid_trap", act, '0);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", act, '0);
    @(negedge clk);
    reset = 1'b1;
    #2;
    issue("load_after_reset", 0,0,1, 32'h0BAD_F00D, 0,0, 32'h9, 5'd31, 1,0,0, 32'h0040_0300, 0,
          ld(32'h0BAD_F00D, 32'h9, 5'd31, 1,0,0,1, 32'h0, 32'h0));
    validE = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
